myspi_regbank: RTL and testbench
================================

MYSPI_REGBANK -- requirements
Module: myspi_regbank

Interface
REQ-001 SHALL have parameter DATA_W, default 16: register and SPI data-word width, 8..32.
REQ-002 SHALL have parameter N_CH, default 10: number of IO channels, 1..32.
REQ-003 SHALL have parameter ADDR_W, default 15: command address field width; command word is ADDR_W+1 bits.
REQ-004 SHALL have parameter BURST_EN, default 1: 1 enables address auto-increment across consecutive data words.
REQ-005 SHALL have port theClock, input, 1 bit: single system clock; all state is on its rising edge.
REQ-006 SHALL have port theReset, input, 1 bit: asynchronous, active-low reset.
REQ-007 SHALL have ports MySPI_clk, MySPI_cs, MySPI_sdi, input, 1 bit each: SPI mode 0; cs is active-low.
REQ-008 SHALL have port MySPI_sdo, output, 1 bit: MSB of the transmit shift register.
REQ-009 SHALL have ports Config and Led70, output, DATA_W each: RW registers. Status SHALL be an input of DATA_W: RO register.
REQ-010 SHALL have port IO_Data_In, input, N_CH*DATA_W: channel k occupies bits [k*DATA_W +: DATA_W].
REQ-011 SHALL have ports IO_Data_Out and IO_Enable_Out, output, N_CH*DATA_W each, using the same packing as IO_Data_In.
REQ-012 SHALL have port Wr_Strobe, output, 1 bit: one-cycle pulse on every register commit.
REQ-013 SHALL have port Frame_Err, output, 1 bit: one-cycle pulse when a frame is aborted mid-word.

Function
REQ-014 SHALL pass MySPI_clk, MySPI_cs and MySPI_sdi each through a 2-flop synchroniser; SCLK edges SHALL be detected from the synchronised clock and a third delay flop.
REQ-015 SHALL use the register map: 0x00 Config (RW); 0x01 Status (RO); 0x02 Led70 (RW); 0x10+2k channel k data; 0x11+2k channel k enable (RW), for k<N_CH.
REQ-016 SHALL return IO_Data_In[k] on a read of channel k data, and SHALL update IO_Data_Out[k] on a write to it.
REQ-017 SHALL return 0 on a read of an unmapped address, and SHALL ignore writes to unmapped or RO addresses (no Wr_Strobe).
REQ-018 SHALL implement FSM states IDLE, CMD, LOAD, DATA, COMMIT.
REQ-019 IDLE->CMD SHALL occur on a synchronised cs falling edge; in CMD, ADDR_W+1 bits are sampled MSB-first on SCLK rising edges. Bit ADDR_W is 1=write, 0=read; the remaining bits are the address.
REQ-020 CMD->LOAD SHALL occur after the last command bit; in LOAD, the transmit register is loaded with the read value of the current address (0 when writing); LOAD->DATA next cycle.
REQ-021 In DATA, the FSM SHALL shift in sdi on SCLK rise and shift out on SCLK fall; after DATA_W bits it SHALL go to COMMIT.
REQ-022 COMMIT SHALL write the received word if the frame is a write and the address is writable, pulse Wr_Strobe, then increment the address (when BURST_EN=1) and go to LOAD.
REQ-023 When BURST_EN=0, the FSM SHALL go from COMMIT to IDLE-wait, ignoring further SCLK edges until cs rises.
REQ-024 The updated output SHALL be visible on the theClock cycle after COMMIT, i.e. at most 4 theClock cycles after the synchronised last-bit SCLK rise.
REQ-025 The address SHALL wrap from 2^ADDR_W-1 to 0 without error.
REQ-026 On cs rise in any state, the FSM SHALL return to IDLE within 3 cycles. If it is mid-word (bit counter non-zero in CMD or DATA), it SHALL pulse Frame_Err, discard the partial word, and write nothing.
REQ-027 If cs rise and the final SCLK rise are detected in the same cycle, the word SHALL complete and commit before IDLE.
REQ-028 The host SHALL keep SCLK high and low phases at least 4 theClock cycles; correct operation is required only under that constraint.
REQ-029 MySPI_sdo SHALL output the transmit MSB continuously, and SHALL be 0 in IDLE.

Reset
REQ-030 While theReset=0, the block SHALL force the FSM to IDLE, the bit counter, address and shift registers to 0, and the synchronisers to the idle level (cs=1, clk=0).
REQ-031 While theReset=0, Config, Led70, IO_Data_Out, IO_Enable_Out, Wr_Strobe, Frame_Err and MySPI_sdo SHALL be held at 0.
REQ-032 Reset assertion mid-frame SHALL abort the frame immediately with no commit.
REQ-033 After reset release, the block SHALL ignore any frame in progress until cs is seen high.

Verification
REQ-034 Write cmd 0x8002, data 0xA5C3 (DATA_W=16) -> Led70=0xA5C3, one Wr_Strobe pulse, no Frame_Err.
REQ-035 Status=0x1234; read cmd 0x0001 -> sdo yields 0x1234 MSB-first; no register changes; Wr_Strobe stays 0.
REQ-036 Burst write cmd 0x8010, data 0x0001, 0x00FF, 0x0002 (N_CH=10) -> IO_Data_Out[0]=0x0001, IO_Enable_Out[0]=0x00FF, IO_Data_Out[1]=0x0002; three Wr_Strobe pulses.
REQ-037 Write cmd 0x8000, 9 data bits, then cs high -> one Frame_Err pulse; Config stays 0.
REQ-038 Write cmd 0x8001 data 0xFFFF, then read 0x7FFF -> Status unchanged, no Wr_Strobe; read returns 0x0000.
REQ-039 Pull theReset low during bit 5 of a write to 0x0002 with Led70=0x00AA -> Led70=0 immediately; after release with cs high, a new write of 0x0055 succeeds.

Source files
------------

// File: rtl/myspi_regbank.sv
// SPI mode-0 slave register bank: command word (R/W + address) followed by data words,
// with optional address auto-increment; all SPI pins are oversampled in the theClock domain.
module myspi_regbank #(
    parameter int DATA_W   = 16,
    parameter int N_CH     = 10,
    parameter int ADDR_W   = 15,
    parameter int BURST_EN = 1
) (
    input  logic                     theClock,
    input  logic                     theReset,
    input  logic                     MySPI_clk,
    input  logic                     MySPI_cs,
    input  logic                     MySPI_sdi,
    output logic                     MySPI_sdo,
    output logic [DATA_W-1:0]        Config,
    output logic [DATA_W-1:0]        Led70,
    input  logic [DATA_W-1:0]        Status,
    input  logic [N_CH*DATA_W-1:0]   IO_Data_In,
    output logic [N_CH*DATA_W-1:0]   IO_Data_Out,
    output logic [N_CH*DATA_W-1:0]   IO_Enable_Out,
    output logic                     Wr_Strobe,
    output logic                     Frame_Err
);

    localparam int CMD_W = ADDR_W + 1;
    localparam int MAXB  = (CMD_W > DATA_W) ? CMD_W : DATA_W;
    localparam int CNT_W = $clog2(MAXB + 1);

    typedef enum logic [2:0] {IDLE, CMD, LOAD, DATA, COMMIT} state_t;

    state_t                  state_q;
    logic [1:0]              cs_sync_q;
    logic [2:0]              clk_sync_q;
    logic [1:0]              sdi_sync_q;
    logic                    cs_dly_q;
    logic [1:0]              warm_q;
    logic                    armed_q;
    logic [CNT_W-1:0]        bit_cnt_q;
    logic [CMD_W-1:0]        cmd_q;
    logic [DATA_W-1:0]       rx_q;
    logic [DATA_W-1:0]       tx_q;
    logic [DATA_W-1:0]       config_q;
    logic [DATA_W-1:0]       led_q;
    logic [N_CH*DATA_W-1:0]  io_out_q;
    logic [N_CH*DATA_W-1:0]  io_en_q;
    logic                    wr_strobe_q;
    logic                    frame_err_q;

    logic                    cs_s;
    logic                    sdi_s;
    logic                    sclk_rise;
    logic                    sclk_fall;
    logic                    cs_fall;
    logic [ADDR_W-1:0]       addr;
    logic                    is_wr;
    logic [DATA_W-1:0]       rd_dat;
    logic                    wr_ok;
    logic [CMD_W-1:0]        cmd_d;
    logic [DATA_W-1:0]       rx_d;
    logic [DATA_W-1:0]       tx_d;

    assign cs_s      = cs_sync_q[1];
    assign sdi_s     = sdi_sync_q[1];
    assign sclk_rise = clk_sync_q[1] & ~clk_sync_q[2];
    assign sclk_fall = ~clk_sync_q[1] & clk_sync_q[2];
    assign cs_fall   = cs_dly_q & ~cs_s;
    assign addr      = cmd_q[ADDR_W-1:0];
    assign is_wr     = cmd_q[ADDR_W];
    assign cmd_d     = {cmd_q[CMD_W-2:0], sdi_s};
    assign rx_d      = {rx_q[DATA_W-2:0], sdi_s};
    assign tx_d      = {tx_q[DATA_W-2:0], 1'b0};

    always_comb begin
        rd_dat = '0;
        wr_ok  = 1'b0;
        if (addr == ADDR_W'(0)) begin
            rd_dat = config_q;
            wr_ok  = 1'b1;
        end
        if (addr == ADDR_W'(1)) rd_dat = Status;
        if (addr == ADDR_W'(2)) begin
            rd_dat = led_q;
            wr_ok  = 1'b1;
        end
        for (int k = 0; k < N_CH; k++) begin
            if (addr == ADDR_W'(16 + 2*k)) begin
                rd_dat = IO_Data_In[k*DATA_W +: DATA_W];
                wr_ok  = 1'b1;
            end
            if (addr == ADDR_W'(17 + 2*k)) begin
                rd_dat = io_en_q[k*DATA_W +: DATA_W];
                wr_ok  = 1'b1;
            end
        end
    end

    always_ff @(posedge theClock or negedge theReset) begin
        if (!theReset) begin
            state_q     <= IDLE;
            cs_sync_q   <= 2'b11;
            clk_sync_q  <= 3'b000;
            sdi_sync_q  <= 2'b00;
            cs_dly_q    <= 1'b1;
            warm_q      <= 2'd0;
            armed_q     <= 1'b0;
            bit_cnt_q   <= '0;
            cmd_q       <= '0;
            rx_q        <= '0;
            tx_q        <= '0;
            config_q    <= '0;
            led_q       <= '0;
            io_out_q    <= '0;
            io_en_q     <= '0;
            wr_strobe_q <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            cs_sync_q   <= {cs_sync_q[0], MySPI_cs};
            clk_sync_q  <= {clk_sync_q[1:0], MySPI_clk};
            sdi_sync_q  <= {sdi_sync_q[0], MySPI_sdi};
            cs_dly_q    <= cs_s;
            wr_strobe_q <= 1'b0;
            frame_err_q <= 1'b0;
            // cs_s only reflects the pin two edges after reset; a frame already
            // running at release must not be mistaken for a fresh cs fall.
            if (warm_q != 2'd2) warm_q <= warm_q + 2'd1;
            if (warm_q == 2'd2 && cs_s) armed_q <= 1'b1;

            case (state_q)
                IDLE: begin
                    if (cs_fall && armed_q) begin
                        state_q   <= CMD;
                        bit_cnt_q <= '0;
                        tx_q      <= '0;
                    end
                end
                CMD: begin
                    if (sclk_rise) begin
                        cmd_q <= cmd_d;
                        if (bit_cnt_q == CNT_W'(CMD_W - 1)) begin
                            state_q   <= LOAD;
                            bit_cnt_q <= '0;
                        end else begin
                            bit_cnt_q <= bit_cnt_q + CNT_W'(1);
                        end
                    end else if (cs_s) begin
                        state_q     <= IDLE;
                        frame_err_q <= (bit_cnt_q != '0);
                    end
                end
                LOAD: begin
                    if (cs_s) begin
                        state_q <= IDLE;
                    end else begin
                        tx_q      <= is_wr ? '0 : rd_dat;
                        bit_cnt_q <= '0;
                        state_q   <= DATA;
                    end
                end
                DATA: begin
                    // The final rise wins over a simultaneous cs rise so the word still commits.
                    if (sclk_rise) begin
                        rx_q <= rx_d;
                        if (bit_cnt_q == CNT_W'(DATA_W - 1)) begin
                            state_q   <= COMMIT;
                            bit_cnt_q <= '0;
                        end else begin
                            bit_cnt_q <= bit_cnt_q + CNT_W'(1);
                        end
                    end else if (cs_s) begin
                        state_q     <= IDLE;
                        frame_err_q <= (bit_cnt_q != '0);
                    end else if (sclk_fall && bit_cnt_q != '0) begin
                        tx_q <= tx_d;
                    end
                end
                COMMIT: begin
                    if (is_wr && wr_ok) begin
                        wr_strobe_q <= 1'b1;
                        if (addr == ADDR_W'(0)) config_q <= rx_q;
                        if (addr == ADDR_W'(2)) led_q    <= rx_q;
                        for (int k = 0; k < N_CH; k++) begin
                            if (addr == ADDR_W'(16 + 2*k)) io_out_q[k*DATA_W +: DATA_W] <= rx_q;
                            if (addr == ADDR_W'(17 + 2*k)) io_en_q[k*DATA_W +: DATA_W]  <= rx_q;
                        end
                    end
                    if (BURST_EN != 0 && !cs_s) begin
                        cmd_q[ADDR_W-1:0] <= addr + ADDR_W'(1);
                        state_q           <= LOAD;
                    end else begin
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign MySPI_sdo     = (state_q != IDLE) & tx_q[DATA_W-1];
    assign Config        = config_q;
    assign Led70         = led_q;
    assign IO_Data_Out   = io_out_q;
    assign IO_Enable_Out = io_en_q;
    assign Wr_Strobe     = wr_strobe_q;
    assign Frame_Err     = frame_err_q;

endmodule

// File: tb/tb_myspi_regbank.sv
// Scenario bench for myspi_regbank: bit-banged SPI host, expected words queued per frame.
module tb_myspi_regbank;

    localparam int DW = 16;
    localparam int NC = 10;
    localparam int H  = 6;

    logic              theClock  = 1'b0;
    logic              theReset  = 1'b0;
    logic              MySPI_clk = 1'b0;
    logic              MySPI_cs  = 1'b1;
    logic              MySPI_sdi = 1'b0;
    logic              MySPI_sdo;
    logic [DW-1:0]     Config;
    logic [DW-1:0]     Led70;
    logic [DW-1:0]     Status = '0;
    logic [NC*DW-1:0]  IO_Data_In = '0;
    logic [NC*DW-1:0]  IO_Data_Out;
    logic [NC*DW-1:0]  IO_Enable_Out;
    logic              Wr_Strobe;
    logic              Frame_Err;

    myspi_regbank #(.DATA_W(DW), .N_CH(NC), .ADDR_W(15), .BURST_EN(1)) dut (
        .theClock(theClock), .theReset(theReset),
        .MySPI_clk(MySPI_clk), .MySPI_cs(MySPI_cs), .MySPI_sdi(MySPI_sdi), .MySPI_sdo(MySPI_sdo),
        .Config(Config), .Led70(Led70), .Status(Status),
        .IO_Data_In(IO_Data_In), .IO_Data_Out(IO_Data_Out), .IO_Enable_Out(IO_Enable_Out),
        .Wr_Strobe(Wr_Strobe), .Frame_Err(Frame_Err)
    );

    always #5 theClock = ~theClock;

    int total = 0;
    int bad   = 0;
    int n_strobe = 0;
    int n_err    = 0;
    time last_rise_t   = 0;
    time last_strobe_t = 0;
    logic [DW-1:0] exp_q[$];
    logic [DW-1:0] tx_words[$];
    logic [DW-1:0] rx_words[$];

    always @(negedge theClock) begin
        if (Wr_Strobe) begin
            n_strobe++;
            last_strobe_t = $time;
        end
        if (Frame_Err) n_err++;
    end

    task automatic spi_bits(input int n, input logic [31:0] val, output logic [31:0] got);
        got = '0;
        for (int i = n - 1; i >= 0; i--) begin
            MySPI_sdi = val[i];
            repeat (H) @(negedge theClock);
            got = {got[30:0], MySPI_sdo};
            MySPI_clk = 1'b1;
            last_rise_t = $time;
            repeat (H) @(negedge theClock);
            MySPI_clk = 1'b0;
        end
    endtask

    task automatic spi_frame(input logic [15:0] cmd);
        logic [31:0] got;
        MySPI_cs = 1'b0;
        repeat (H) @(negedge theClock);
        spi_bits(16, {16'h0, cmd}, got);
        foreach (tx_words[i]) begin
            spi_bits(16, {16'h0, tx_words[i]}, got);
            rx_words.push_back(got[15:0]);
        end
        repeat (H) @(negedge theClock);
        MySPI_cs = 1'b1;
        repeat (3*H) @(negedge theClock);
    endtask

    task automatic test_reset();
        MySPI_cs = 1'b1; MySPI_clk = 1'b0; theReset = 1'b0;
        repeat (3) @(negedge theClock);
        total++; if (Config !== 16'h0) begin bad++; $display("FAIL rst_config got=%h want=0", Config); end
        total++; if (Led70 !== 16'h0) begin bad++; $display("FAIL rst_led70 got=%h want=0", Led70); end
        total++; if (IO_Data_Out !== '0) begin bad++; $display("FAIL rst_io_data got=%h want=0", IO_Data_Out); end
        total++; if (IO_Enable_Out !== '0) begin bad++; $display("FAIL rst_io_en got=%h want=0", IO_Enable_Out); end
        total++; if (Wr_Strobe !== 1'b0) begin bad++; $display("FAIL rst_strobe got=%b want=0", Wr_Strobe); end
        total++; if (Frame_Err !== 1'b0) begin bad++; $display("FAIL rst_ferr got=%b want=0", Frame_Err); end
        total++; if (MySPI_sdo !== 1'b0) begin bad++; $display("FAIL rst_sdo got=%b want=0", MySPI_sdo); end
        theReset = 1'b1;
        repeat (5) @(negedge theClock);
    endtask

    task automatic test_write_led();
        int s0, e0;
        logic [DW-1:0] e;
        s0 = n_strobe; e0 = n_err;
        tx_words.delete(); tx_words.push_back(16'hA5C3);
        exp_q.push_back(16'hA5C3);
        spi_frame(16'h8002);
        e = exp_q.pop_front();
        total++; if (Led70 !== e) begin bad++; $display("FAIL wr_led70 got=%h want=%h", Led70, e); end
        total++; if (n_strobe - s0 !== 1) begin bad++; $display("FAIL wr_strobe_cnt got=%0d want=1", n_strobe - s0); end
        total++; if (n_err - e0 !== 0) begin bad++; $display("FAIL wr_ferr_cnt got=%0d want=0", n_err - e0); end
        total++; if (last_strobe_t < last_rise_t || last_strobe_t - last_rise_t > 60) begin
            bad++; $display("FAIL wr_latency got=%0t want<=60", last_strobe_t - last_rise_t);
        end
        total++; if (MySPI_sdo !== 1'b0) begin bad++; $display("FAIL idle_sdo got=%b want=0", MySPI_sdo); end
    endtask

    task automatic test_read_status();
        int s0;
        logic [DW-1:0] e, r;
        s0 = n_strobe;
        Status = 16'h1234;
        tx_words.delete(); tx_words.push_back(16'h0000);
        rx_words.delete();
        exp_q.push_back(16'h1234);
        spi_frame(16'h0001);
        e = exp_q.pop_front(); r = rx_words.pop_front();
        total++; if (r !== e) begin bad++; $display("FAIL rd_status got=%h want=%h", r, e); end
        total++; if (n_strobe - s0 !== 0) begin bad++; $display("FAIL rd_strobe_cnt got=%0d want=0", n_strobe - s0); end
        total++; if (Led70 !== 16'hA5C3) begin bad++; $display("FAIL rd_led70_kept got=%h want=a5c3", Led70); end
        total++; if (Config !== 16'h0) begin bad++; $display("FAIL rd_config_kept got=%h want=0", Config); end
    endtask

    task automatic test_burst();
        int s0;
        logic [DW-1:0] e, r;
        s0 = n_strobe;
        IO_Data_In[15:0]  = 16'hBEEF;
        IO_Data_In[31:16] = 16'h1357;
        tx_words.delete();
        tx_words.push_back(16'h0001); tx_words.push_back(16'h00FF); tx_words.push_back(16'h0002);
        exp_q.push_back(16'h0001); exp_q.push_back(16'h00FF); exp_q.push_back(16'h0002);
        spi_frame(16'h8010);
        e = exp_q.pop_front();
        total++; if (IO_Data_Out[15:0] !== e) begin bad++; $display("FAIL burst_data0 got=%h want=%h", IO_Data_Out[15:0], e); end
        e = exp_q.pop_front();
        total++; if (IO_Enable_Out[15:0] !== e) begin bad++; $display("FAIL burst_en0 got=%h want=%h", IO_Enable_Out[15:0], e); end
        e = exp_q.pop_front();
        total++; if (IO_Data_Out[31:16] !== e) begin bad++; $display("FAIL burst_data1 got=%h want=%h", IO_Data_Out[31:16], e); end
        total++; if (n_strobe - s0 !== 3) begin bad++; $display("FAIL burst_strobe_cnt got=%0d want=3", n_strobe - s0); end

        tx_words.delete();
        repeat (3) tx_words.push_back(16'h0000);
        rx_words.delete();
        exp_q.push_back(16'hBEEF); exp_q.push_back(16'h00FF); exp_q.push_back(16'h1357);
        spi_frame(16'h0010);
        for (int i = 0; i < 3; i++) begin
            e = exp_q.pop_front(); r = rx_words.pop_front();
            total++; if (r !== e) begin bad++; $display("FAIL burst_rd%0d got=%h want=%h", i, r, e); end
        end
    endtask

    task automatic test_frame_err();
        int s0, e0;
        logic [31:0] got;
        s0 = n_strobe; e0 = n_err;
        MySPI_cs = 1'b0;
        repeat (H) @(negedge theClock);
        spi_bits(16, 32'h8000, got);
        spi_bits(9, 32'h1FF, got);
        repeat (H) @(negedge theClock);
        MySPI_cs = 1'b1;
        repeat (3*H) @(negedge theClock);
        total++; if (n_err - e0 !== 1) begin bad++; $display("FAIL ferr_cnt got=%0d want=1", n_err - e0); end
        total++; if (Config !== 16'h0) begin bad++; $display("FAIL ferr_config got=%h want=0", Config); end
        total++; if (n_strobe - s0 !== 0) begin bad++; $display("FAIL ferr_strobe_cnt got=%0d want=0", n_strobe - s0); end
    endtask

    task automatic test_ro_unmapped();
        int s0;
        logic [DW-1:0] e, r;
        s0 = n_strobe;
        tx_words.delete(); tx_words.push_back(16'hFFFF);
        spi_frame(16'h8001);
        total++; if (n_strobe - s0 !== 0) begin bad++; $display("FAIL ro_strobe_cnt got=%0d want=0", n_strobe - s0); end

        tx_words.delete(); tx_words.push_back(16'h0000);
        rx_words.delete();
        exp_q.push_back(16'h0000);
        spi_frame(16'h7FFF);
        e = exp_q.pop_front(); r = rx_words.pop_front();
        total++; if (r !== e) begin bad++; $display("FAIL unmapped_rd got=%h want=%h", r, e); end

        tx_words.delete(); tx_words.push_back(16'h3C5A);
        exp_q.push_back(16'h3C5A);
        spi_frame(16'h8000);
        e = exp_q.pop_front();
        total++; if (Config !== e) begin bad++; $display("FAIL wr_config got=%h want=%h", Config, e); end

        tx_words.delete(); tx_words.push_back(16'h0000); tx_words.push_back(16'h0000);
        rx_words.delete();
        exp_q.push_back(16'h0000); exp_q.push_back(16'h3C5A);
        spi_frame(16'h7FFF);
        for (int i = 0; i < 2; i++) begin
            e = exp_q.pop_front(); r = rx_words.pop_front();
            total++; if (r !== e) begin bad++; $display("FAIL wrap_rd%0d got=%h want=%h", i, r, e); end
        end
    endtask

    task automatic test_reset_mid();
        int s0;
        logic [31:0] got;
        logic [DW-1:0] e;
        tx_words.delete(); tx_words.push_back(16'h00AA);
        spi_frame(16'h8002);
        total++; if (Led70 !== 16'h00AA) begin bad++; $display("FAIL pre_rst_led70 got=%h want=00aa", Led70); end

        MySPI_cs = 1'b0;
        repeat (H) @(negedge theClock);
        spi_bits(16, 32'h8002, got);
        spi_bits(5, 32'h1B, got);
        theReset = 1'b0;
        #1;
        total++; if (Led70 !== 16'h0) begin bad++; $display("FAIL midrst_led70 got=%h want=0", Led70); end
        total++; if (MySPI_sdo !== 1'b0) begin bad++; $display("FAIL midrst_sdo got=%b want=0", MySPI_sdo); end
        MySPI_cs = 1'b1;
        repeat (4) @(negedge theClock);
        theReset = 1'b1;
        repeat (6) @(negedge theClock);
        s0 = n_strobe;
        tx_words.delete(); tx_words.push_back(16'h0055);
        exp_q.push_back(16'h0055);
        spi_frame(16'h8002);
        e = exp_q.pop_front();
        total++; if (Led70 !== e) begin bad++; $display("FAIL postrst_led70 got=%h want=%h", Led70, e); end
        total++; if (n_strobe - s0 !== 1) begin bad++; $display("FAIL postrst_strobe_cnt got=%0d want=1", n_strobe - s0); end

        // Release reset with cs already low: that frame must be ignored.
        theReset = 1'b0;
        MySPI_cs = 1'b0;
        repeat (3) @(negedge theClock);
        theReset = 1'b1;
        repeat (H) @(negedge theClock);
        s0 = n_strobe;
        spi_bits(16, 32'h8002, got);
        spi_bits(16, 32'h1111, got);
        repeat (H) @(negedge theClock);
        MySPI_cs = 1'b1;
        repeat (3*H) @(negedge theClock);
        total++; if (Led70 !== 16'h0) begin bad++; $display("FAIL stale_frame_led70 got=%h want=0", Led70); end
        total++; if (n_strobe - s0 !== 0) begin bad++; $display("FAIL stale_frame_strobe got=%0d want=0", n_strobe - s0); end
    endtask

    task automatic test_back_to_back();
        logic [DW-1:0] e, r;
        tx_words.delete(); tx_words.push_back(16'h0F0F);
        spi_frame(16'h8002);
        tx_words.delete(); tx_words.push_back(16'h0000);
        rx_words.delete();
        exp_q.push_back(16'h0F0F);
        spi_frame(16'h0002);
        e = exp_q.pop_front(); r = rx_words.pop_front();
        total++; if (r !== e) begin bad++; $display("FAIL b2b_rd got=%h want=%h", r, e); end
        total++; if (Led70 !== 16'h0F0F) begin bad++; $display("FAIL b2b_led70 got=%h want=0f0f", Led70); end
    endtask

    initial begin
        test_reset();
        test_write_led();
        test_read_status();
        test_burst();
        test_frame_err();
        test_ro_unmapped();
        test_reset_mid();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
